// File: rtl/wisard_sample_streamer_pkg.sv
// Shared constants for the wisard sample streamer.
// FSM encodings, bank count and sample counter width.
package wisard_stream_pkg;

  localparam int SAMPLE_CNT_W = 16;
  localparam int N_BANKS      = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_STREAM   = 2'd1;
  localparam state_t ST_WAIT_RES = 2'd2;

endpackage

// File: rtl/wisard_sample_streamer_if.sv
// Load-side and stream-side bus of the wisard sample streamer.
// master = loader/consumer side, slave = streamer side.
interface wisard_sample_streamer_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 6
);

  logic                     ld_valid;
  logic [INDEX_WIDTH-1:0]   ld_index;
  logic [ADDRESS_WIDTH-1:0] ld_addr;
  logic                     ld_commit;
  logic                     ld_ready;
  logic                     ld_drop;
  logic                     stream_ready;
  logic                     sop;
  logic                     sink_valid;
  logic                     eop;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [INDEX_WIDTH-1:0]   index;
  logic                     result_valid;

  modport master (
    output ld_valid, ld_index, ld_addr, ld_commit,
    output stream_ready, result_valid,
    input  ld_ready, ld_drop,
    input  sop, sink_valid, eop, addr, index
  );

  modport slave (
    input  ld_valid, ld_index, ld_addr, ld_commit,
    input  stream_ready, result_valid,
    output ld_ready, ld_drop,
    output sop, sink_valid, eop, addr, index
  );

endinterface

// File: rtl/wisard_sample_bank.sv
// Ping-pong sample storage: 2 banks x N_RAMS addresses.
// One write port, one read port with registered read data.
module wisard_sample_bank
  import wisard_stream_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 6,
  parameter int N_RAMS        = 49
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we_i,
  input  logic                     wbank_i,
  input  logic [INDEX_WIDTH-1:0]   widx_i,
  input  logic [ADDRESS_WIDTH-1:0] wdata_i,
  input  logic                     re_i,
  input  logic                     rbank_i,
  input  logic [INDEX_WIDTH-1:0]   ridx_i,
  output logic [ADDRESS_WIDTH-1:0] rdata_o
);

  logic [ADDRESS_WIDTH-1:0] mem_q [N_BANKS][N_RAMS];
  logic [ADDRESS_WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wbank_i][widx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[rbank_i][ridx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wisard_sample_streamer.sv
// Ping-pong sample buffer streaming one packet per sample to wisard.
// Define WISARD_WAIT_RESULT_EN to wait for result_valid between packets.
module wisard_sample_streamer
  import wisard_stream_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int INDEX_WIDTH   = 6,
  parameter int N_RAMS        = 49
) (
  input  logic                    clk,
  input  logic                    rst_n,
  wisard_sample_streamer_if.slave bus,
  output logic                    busy,
  output logic [SAMPLE_CNT_W-1:0] sample_cnt
);

  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(N_RAMS - 1);

  state_t                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   cnt_q, cnt_d;
  logic                     rd_bank_q, rd_bank_d;
  logic                     wr_bank_q, wr_bank_d;
  logic [N_BANKS-1:0]       full_q, full_d;
  logic [SAMPLE_CNT_W-1:0]  scnt_q, scnt_d;
  logic                     drop_q, drop_d;

  logic                     ld_rdy;
  logic                     idx_ok;
  logic                     wr_en;
  logic                     commit;
  logic                     valid;
  logic                     accept;
  logic                     last;
  logic                     rd_en;
  logic                     rd_sel;
  logic [INDEX_WIDTH-1:0]   rd_idx;
  logic [ADDRESS_WIDTH-1:0] rdata;

  assign ld_rdy = ~full_q[wr_bank_q];
  assign idx_ok = bus.ld_index <= LAST;
  assign wr_en  = bus.ld_valid & ld_rdy & idx_ok;
  assign commit = bus.ld_commit & ld_rdy;
  assign valid  = state_q == ST_STREAM;
  assign accept = valid & bus.stream_ready;
  assign last   = accept & (cnt_q == LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_bank_d = rd_bank_q;
    wr_bank_d = wr_bank_q ^ commit;
    full_d    = full_q;
    scnt_d    = scnt_q;
    rd_en     = 1'b0;
    rd_sel    = rd_bank_q;
    rd_idx    = cnt_q;
    drop_d    = drop_q
              | (bus.ld_valid & ~(ld_rdy & idx_ok))
              | (bus.ld_commit & ~ld_rdy);

    // Release first so a same-cycle commit on the other bank survives.
    if (last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      scnt_d            = scnt_q + 1'b1;
    end
    if (commit) begin
      full_d[wr_bank_q] = 1'b1;
    end

    unique case (1'b1)
      state_q == ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
          rd_en   = 1'b1;
          rd_idx  = '0;
        end
      end
      state_q == ST_STREAM: begin
        if (last) begin
`ifdef WISARD_WAIT_RESULT_EN
          state_d = ST_WAIT_RES;
`else
          if (full_q[~rd_bank_q]) begin
            cnt_d  = '0;
            rd_en  = 1'b1;
            rd_sel = ~rd_bank_q;
            rd_idx = '0;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end else if (accept) begin
          cnt_d  = cnt_q + 1'b1;
          rd_en  = 1'b1;
          rd_idx = cnt_q + 1'b1;
        end
      end
`ifdef WISARD_WAIT_RESULT_EN
      state_q == ST_WAIT_RES: begin
        if (bus.result_valid) begin
          if (full_q[rd_bank_q]) begin
            state_d = ST_STREAM;
            cnt_d   = '0;
            rd_en   = 1'b1;
            rd_idx  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      full_q    <= '0;
      scnt_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      scnt_q    <= scnt_d;
      drop_q    <= drop_d;
    end
  end

  wisard_sample_bank #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .INDEX_WIDTH   (INDEX_WIDTH),
    .N_RAMS        (N_RAMS)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .wbank_i (wr_bank_q),
    .widx_i  (bus.ld_index),
    .wdata_i (bus.ld_addr),
    .re_i    (rd_en),
    .rbank_i (rd_sel),
    .ridx_i  (rd_idx),
    .rdata_o (rdata)
  );

  assign bus.ld_ready   = ld_rdy;
  assign bus.ld_drop    = drop_q;
  assign bus.sink_valid = valid;
  assign bus.sop        = valid & (cnt_q == '0);
  assign bus.eop        = valid & (cnt_q == LAST);
  assign bus.index      = valid ? cnt_q : '0;
  assign bus.addr       = valid ? rdata : '0;
  assign busy           = state_q != ST_IDLE;
  assign sample_cnt     = scnt_q;

endmodule

// File: tb/tb_wisard_sample_streamer.sv
// Self-checking bench for wisard_sample_streamer.
// Directed vectors, corner sequences and a queue-based random model.
module tb_wisard_sample_streamer;
  import wisard_stream_pkg::*;

  localparam int AW = 8;
  localparam int IW = 6;
  localparam int N  = 49;
`ifdef WISARD_WAIT_RESULT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef logic [AW-1:0] sample_t [N];

  typedef struct {
    logic          commit;
    logic          rdy;
    logic          valid;
    logic          sop;
    logic          eop;
    logic [IW-1:0] idx;
    logic [AW-1:0] addr;
    logic          busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  wisard_sample_streamer_if #(
    .ADDRESS_WIDTH (AW),
    .INDEX_WIDTH   (IW)
  ) bus ();

  wisard_sample_streamer #(
    .ADDRESS_WIDTH (AW),
    .INDEX_WIDTH   (IW),
    .N_RAMS        (N)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(string t, sample_t s, int i);
    chk({t, "_valid"}, 32'(bus.sink_valid), 32'd1);
    chk({t, "_sop"}, 32'(bus.sop), 32'(i == 0));
    chk({t, "_eop"}, 32'(bus.eop), 32'(i == N - 1));
    chk({t, "_index"}, 32'(bus.index), 32'(i));
    chk({t, "_addr"}, 32'(bus.addr), 32'(s[i]));
  endtask

  task automatic load_sample(sample_t s);
    for (int i = 0; i < N; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_index = IW'(i);
      bus.ld_addr  = s[i];
      step();
    end
    bus.ld_valid = 1'b0;
    bus.ld_index = '0;
  endtask

  // Random-phase model: bank contents, pending packet queue.
  sample_t mb [2];
  bit      kn [2][N];
  sample_t q [$];

  function automatic bit all_known(int b, bit lv, int li);
    for (int j = 0; j < N; j++) begin
      if (!kn[b][j] && !(lv && li == j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    sample_t p0, pa, pb, pc;
    vec_t    tv [7];
    bit      seen_eop;
    int      wb, bp, done;
    bit      ev, lv, lc, rdy, rdy_p, acc, drain;
    int      li;
    logic [AW-1:0] la;

    tv[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 8'h10, 1'b1};
    tv[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1, 8'h11, 1'b1};
    tv[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 8'h11, 1'b1};
    tv[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 8'h11, 1'b1};
    tv[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd2, 8'h12, 1'b1};
    tv[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd3, 8'h13, 1'b1};

    for (int i = 0; i < N; i++) begin
      p0[i] = AW'(i + 16);
      pa[i] = AW'(i * 3 + 7);
      pb[i] = AW'(255 - i);
      pc[i] = AW'(i * 5 + 1);
    end

    bus.ld_valid     = 1'b0;
    bus.ld_index     = '0;
    bus.ld_addr      = '0;
    bus.ld_commit    = 1'b0;
    bus.stream_ready = 1'b0;
    bus.result_valid = 1'b0;

    // Reset values
    #12;
    chk("rst_sop", 32'(bus.sop), 32'd0);
    chk("rst_valid", 32'(bus.sink_valid), 32'd0);
    chk("rst_eop", 32'(bus.eop), 32'd0);
    chk("rst_addr", 32'(bus.addr), 32'd0);
    chk("rst_index", 32'(bus.index), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_drop", 32'(bus.ld_drop), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Single packet: latency and stall via vector table
    load_sample(p0);
    for (int r = 0; r < 7; r++) begin
      bus.ld_commit    = tv[r].commit;
      bus.stream_ready = tv[r].rdy;
      step();
      bus.ld_commit = 1'b0;
      chk($sformatf("tv%0d_valid", r),
          32'(bus.sink_valid), 32'(tv[r].valid));
      chk($sformatf("tv%0d_sop", r),
          32'(bus.sop), 32'(tv[r].sop));
      chk($sformatf("tv%0d_eop", r),
          32'(bus.eop), 32'(tv[r].eop));
      chk($sformatf("tv%0d_index", r),
          32'(bus.index), 32'(tv[r].idx));
      chk($sformatf("tv%0d_addr", r),
          32'(bus.addr), 32'(tv[r].addr));
      chk($sformatf("tv%0d_busy", r),
          32'(busy), 32'(tv[r].busy));
    end
    for (int i = 4; i < N; i++) begin
      step();
      check_beat("pk0", p0, i);
    end
    chk("pk0_last_addr", 32'(bus.addr), 32'h40);
    step();
    chk("pk0_after_valid", 32'(bus.sink_valid), 32'd0);
    chk("pk0_after_cnt", 32'(sample_cnt), 32'd1);
    chk("pk0_after_busy", 32'(busy), 32'(WAIT_EN));
`ifdef WISARD_WAIT_RESULT_EN
    bus.result_valid = 1'b1;
    step();
    bus.result_valid = 1'b0;
    chk("pk0_wait_exit", 32'(busy), 32'd0);
`endif

    // Two samples queued, overflow attempt, back-to-back stream
    bus.stream_ready = 1'b0;
    load_sample(pa);
    bus.ld_commit = 1'b1;
    step();
    bus.ld_commit = 1'b0;
    chk("two_ready_b", 32'(bus.ld_ready), 32'd1);
    load_sample(pb);
    bus.ld_commit = 1'b1;
    step();
    bus.ld_commit = 1'b0;
    chk("two_full_ready", 32'(bus.ld_ready), 32'd0);
    chk("two_drop_pre", 32'(bus.ld_drop), 32'd0);
    bus.ld_valid  = 1'b1;
    bus.ld_index  = 6'd3;
    bus.ld_addr   = 8'hEE;
    bus.ld_commit = 1'b1;
    step();
    bus.ld_valid  = 1'b0;
    bus.ld_index  = '0;
    bus.ld_commit = 1'b0;
    chk("two_drop_set", 32'(bus.ld_drop), 32'd1);
    bus.stream_ready = 1'b1;
    for (int k = 0; k < 2 * N; k++) begin
      if (k < N) check_beat("pkA", pa, k);
      else       check_beat("pkB", pb, k - N);
      step();
`ifdef WISARD_WAIT_RESULT_EN
      if (k == N - 1) begin
        for (int w = 0; w < 10; w++) begin
          chk("wait_valid", 32'(bus.sink_valid), 32'd0);
          chk("wait_busy", 32'(busy), 32'd1);
          step();
        end
        bus.result_valid = 1'b1;
        step();
        bus.result_valid = 1'b0;
      end
`endif
    end
    chk("two_cnt", 32'(sample_cnt), 32'd3);
    for (int w = 0; w < 5; w++) begin
      chk("two_no_third", 32'(bus.sink_valid), 32'd0);
      step();
    end
    chk("two_drop_sticky", 32'(bus.ld_drop), 32'd1);
`ifdef WISARD_WAIT_RESULT_EN
    bus.result_valid = 1'b1;
    step();
    bus.result_valid = 1'b0;
`endif

    // Reset in the middle of a packet
    load_sample(pc);
    bus.ld_commit = 1'b1;
    step();
    bus.ld_commit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.sink_valid && bus.index == 6'd20) break;
      step();
    end
    chk("mid_reach_20", 32'(bus.index), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sop", 32'(bus.sop), 32'd0);
    chk("mid_rst_valid", 32'(bus.sink_valid), 32'd0);
    chk("mid_rst_eop", 32'(bus.eop), 32'd0);
    chk("mid_rst_addr", 32'(bus.addr), 32'd0);
    chk("mid_rst_index", 32'(bus.index), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cnt", 32'(sample_cnt), 32'd0);
    chk("mid_rst_drop", 32'(bus.ld_drop), 32'd0);
    chk("mid_rst_ready", 32'(bus.ld_ready), 32'd1);
    #4;
    rst_n = 1'b1;
    seen_eop = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (bus.eop || busy) seen_eop = 1'b1;
    end
    chk("mid_no_eop_no_busy", 32'(seen_eop), 32'd0);

    // Randomized traffic against the packet-queue model
    wb = 0;
    bp = 0;
    done = 0;
    ev = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      drain = c >= 5000;
      if (drain && q.size() == 0 && !bus.sink_valid) break;
      rdy_p = q.size() < 2;
      lv = !drain && rdy_p && ($urandom_range(1, 0) == 1);
      li = $urandom_range(N - 1, 0);
      la = AW'($urandom);
      lc = 1'b0;
      if (!drain && rdy_p && $urandom_range(29, 0) == 0)
        lc = all_known(wb, lv, li);
      rdy = drain || ($urandom_range(3, 0) != 0);
      bus.ld_valid     = lv;
      bus.ld_index     = IW'(li);
      bus.ld_addr      = la;
      bus.ld_commit    = lc;
      bus.stream_ready = rdy;
      bus.result_valid = ($urandom_range(7, 0) == 0);
      chk("rnd_ld_ready", 32'(bus.ld_ready), 32'(rdy_p));
      chk("rnd_ld_drop", 32'(bus.ld_drop), 32'd0);
      if (ev) chk("rnd_no_bubble", 32'(bus.sink_valid), 32'd1);
      if (bus.sink_valid) begin
        chk("rnd_beat_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) check_beat("rnd", q[0], bp);
      end
      acc = bus.sink_valid && rdy && q.size() != 0;
      if (lv) begin
        mb[wb][li] = la;
        kn[wb][li] = 1'b1;
      end
      ev = bus.sink_valid && !rdy;
      if (acc) begin
        if (bp == N - 1) begin
          void'(q.pop_front());
          bp = 0;
          done++;
          ev = (q.size() != 0) && !WAIT_EN;
        end else begin
          bp++;
          ev = 1'b1;
        end
      end
      if (lc) begin
        q.push_back(mb[wb]);
        wb ^= 1;
      end
      step();
      chk("rnd_sample_cnt", 32'(sample_cnt), 32'(16'(done)));
    end
    bus.ld_valid     = 1'b0;
    bus.ld_commit    = 1'b0;
    bus.result_valid = 1'b0;
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_activity", 32'(done > 5), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
